// File: rtl/scene_draw_sequencer.sv
// Level/scene draw sequencer: clears the object store, draws the background, then
// places and draws every object of every class; on each frame in PLAY it redraws live objects.
module scene_draw_sequencer #(
    parameter int NUM_CLASSES = 2,
    parameter int MAX_OBJ     = 6,
    parameter int CLS_W       = 1,
    parameter int IDX_W       = 3
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           go,
    input  logic                           frame,
    input  logic                           game_end,
    input  logic [NUM_CLASSES*MAX_OBJ-1:0] obj_alive,
    input  logic                           draw_background_done,
    input  logic                           draw_object_done,
    output logic                           enable_draw_background,
    output logic                           enable_draw_object,
    output logic [CLS_W-1:0]               obj_class,
    output logic [IDX_W-1:0]               obj_index,
    output logic                           enable_random,
    output logic                           rand_sel,
    output logic                           resetn_objects,
    output logic                           playing,
    output logic [7:0]                     dropped_frames
);

    typedef enum logic [3:0] {
        S_IDLE, S_CLEAR, S_BG, S_PICK, S_GEN_X, S_GEN_Y, S_OBJ, S_PLAY, S_DONE
    } state_t;

    localparam logic [CLS_W-1:0] LAST_CLS = CLS_W'(NUM_CLASSES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_OBJ - 1);

    state_t           state_reg, state_next;
    logic             populate_reg, populate_next;
    logic             pending_reg, pending_next;
    logic             wrapped_reg, wrapped_next;
    logic [CLS_W-1:0] cls_reg, cls_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [7:0]       drop_reg, drop_next;

    logic             cur_alive;
    logic             go_ok;
    logic             in_pass;
    logic [CLS_W-1:0] adv_cls;
    logic [IDX_W-1:0] adv_idx;
    logic             adv_wrap;

    // Live bit of the current (class, index), selected without a wide multiply.
    always_comb begin
        cur_alive = 1'b0;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            for (int i = 0; i < MAX_OBJ; i++) begin
                if (cls_reg == CLS_W'(c) && idx_reg == IDX_W'(i))
                    cur_alive = obj_alive[c*MAX_OBJ + i];
            end
        end
    end

    // Advancing past the last object holds the counters and raises the wrap flag instead.
    always_comb begin
        adv_cls  = cls_reg;
        adv_idx  = idx_reg;
        adv_wrap = 1'b0;
        if (idx_reg == LAST_IDX) begin
            if (cls_reg == LAST_CLS) begin
                adv_wrap = 1'b1;
            end else begin
                adv_idx = '0;
                adv_cls = cls_reg + 1'b1;
            end
        end else begin
            adv_idx = idx_reg + 1'b1;
        end
    end

    assign go_ok   = go && (state_reg == S_IDLE || state_reg == S_DONE);
    assign in_pass = (state_reg == S_CLEAR) || (state_reg == S_BG) || (state_reg == S_PICK) ||
                     (state_reg == S_GEN_X) || (state_reg == S_GEN_Y) || (state_reg == S_OBJ);

    always_comb begin
        state_next    = state_reg;
        populate_next = populate_reg;
        pending_next  = pending_reg;
        wrapped_next  = wrapped_reg;
        cls_next      = cls_reg;
        idx_next      = idx_reg;
        drop_next     = drop_reg;

        case (state_reg)
            S_IDLE, S_DONE: begin
                if (go) state_next = S_CLEAR;
            end
            S_CLEAR: begin
                cls_next     = '0;
                idx_next     = '0;
                wrapped_next = 1'b0;
                state_next   = S_BG;
            end
            S_BG: begin
                if (draw_background_done) state_next = S_PICK;
            end
            S_PICK: begin
                if (wrapped_reg) begin
                    state_next    = S_PLAY;
                    populate_next = 1'b0;
                end else if (populate_reg) begin
                    state_next = S_GEN_X;
                end else if (cur_alive) begin
                    state_next = S_OBJ;
                end else begin
                    cls_next     = adv_cls;
                    idx_next     = adv_idx;
                    wrapped_next = adv_wrap;
                end
            end
            S_GEN_X: state_next = S_GEN_Y;
            S_GEN_Y: state_next = S_OBJ;
            S_OBJ: begin
                if (draw_object_done) begin
                    state_next   = S_PICK;
                    cls_next     = adv_cls;
                    idx_next     = adv_idx;
                    wrapped_next = adv_wrap;
                end
            end
            S_PLAY: begin
                if (game_end || pending_reg) begin
                    state_next = S_DONE;
                end else if (frame) begin
                    state_next    = S_BG;
                    populate_next = 1'b0;
                    cls_next      = '0;
                    idx_next      = '0;
                    wrapped_next  = 1'b0;
                end
            end
            default: state_next = S_IDLE;
        endcase

        // An end request during a pass is deferred until the pass reaches PLAY.
        if (go_ok || state_reg == S_DONE)
            pending_next = 1'b0;
        else if (game_end && state_reg != S_PLAY)
            pending_next = 1'b1;

        if (go_ok)
            drop_next = '0;
        else if (frame && in_pass && drop_reg != 8'hFF)
            drop_next = drop_reg + 8'd1;

        if (go_ok) populate_next = 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= S_IDLE;
            populate_reg <= 1'b0;
            pending_reg  <= 1'b0;
            wrapped_reg  <= 1'b0;
            cls_reg      <= '0;
            idx_reg      <= '0;
            drop_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            populate_reg <= populate_next;
            pending_reg  <= pending_next;
            wrapped_reg  <= wrapped_next;
            cls_reg      <= cls_next;
            idx_reg      <= idx_next;
            drop_reg     <= drop_next;
        end
    end

    // Outputs decode the state register directly so reset forces them low at once.
    assign enable_draw_background = (state_reg == S_BG);
    assign enable_draw_object     = (state_reg == S_OBJ);
    assign enable_random          = (state_reg == S_GEN_X) || (state_reg == S_GEN_Y);
    assign rand_sel               = (state_reg == S_GEN_Y);
    assign resetn_objects         = (state_reg != S_CLEAR);
    assign playing                = (state_reg == S_PLAY);
    assign obj_class              = cls_reg;
    assign obj_index              = idx_reg;
    assign dropped_frames         = drop_reg;

endmodule

// File: tb/tb_scene_draw_sequencer.sv
// Scoreboard bench for scene_draw_sequencer with 2 classes of 3 objects.
module tb_scene_draw_sequencer;

    localparam int NC = 2;
    localparam int MO = 3;
    localparam int CW = 1;
    localparam int IW = 2;

    localparam int EV_CLR  = 1;
    localparam int EV_BG   = 2;
    localparam int EV_RX   = 3;
    localparam int EV_RY   = 4;
    localparam int EV_OBJ  = 5;
    localparam int EV_PLAY = 6;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          go = 1'b0;
    logic          frame = 1'b0;
    logic          game_end = 1'b0;
    logic [NC*MO-1:0] obj_alive = '1;
    logic          bg_done = 1'b1;
    logic          obj_done = 1'b1;
    logic          enable_draw_background;
    logic          enable_draw_object;
    logic [CW-1:0] obj_class;
    logic [IW-1:0] obj_index;
    logic          enable_random;
    logic          rand_sel;
    logic          resetn_objects;
    logic          playing;
    logic [7:0]    dropped_frames;

    int vec_cnt = 0;
    int miss_cnt = 0;
    int exp_q[$];
    logic bg_prev = 1'b0, obj_prev = 1'b0, play_prev = 1'b0;

    scene_draw_sequencer #(.NUM_CLASSES(NC), .MAX_OBJ(MO), .CLS_W(CW), .IDX_W(IW)) dut (
        .clk                    (clk),
        .resetn                 (resetn),
        .go                     (go),
        .frame                  (frame),
        .game_end               (game_end),
        .obj_alive              (obj_alive),
        .draw_background_done   (bg_done),
        .draw_object_done       (obj_done),
        .enable_draw_background (enable_draw_background),
        .enable_draw_object     (enable_draw_object),
        .obj_class              (obj_class),
        .obj_index              (obj_index),
        .enable_random          (enable_random),
        .rand_sel               (rand_sel),
        .resetn_objects         (resetn_objects),
        .playing                (playing),
        .dropped_frames         (dropped_frames)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    function automatic int ev(input int kind, input int c, input int i);
        return (kind << 8) | (c << 4) | i;
    endfunction

    task automatic sb_pop(input int got);
        if (exp_q.size() == 0) chk("unexpected_event", got, 0);
        else chk("event", got, exp_q.pop_front());
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (resetn) begin
            if (!resetn_objects) sb_pop(ev(EV_CLR, 0, 0));
            if (enable_draw_background && !bg_prev) sb_pop(ev(EV_BG, 0, 0));
            if (enable_random)
                sb_pop(ev(rand_sel ? EV_RY : EV_RX, int'(obj_class), int'(obj_index)));
            if (enable_draw_object && !obj_prev)
                sb_pop(ev(EV_OBJ, int'(obj_class), int'(obj_index)));
            if (playing && !play_prev) sb_pop(ev(EV_PLAY, 0, 0));
        end
        bg_prev   <= enable_draw_background;
        obj_prev  <= enable_draw_object;
        play_prev <= playing;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_populate();
        exp_q.push_back(ev(EV_CLR, 0, 0));
        exp_q.push_back(ev(EV_BG, 0, 0));
        for (int c = 0; c < NC; c++)
            for (int i = 0; i < MO; i++) begin
                exp_q.push_back(ev(EV_RX, c, i));
                exp_q.push_back(ev(EV_RY, c, i));
                exp_q.push_back(ev(EV_OBJ, c, i));
            end
        exp_q.push_back(ev(EV_PLAY, 0, 0));
    endtask

    task automatic push_redraw(input logic [NC*MO-1:0] mask);
        exp_q.push_back(ev(EV_BG, 0, 0));
        for (int c = 0; c < NC; c++)
            for (int i = 0; i < MO; i++)
                if (mask[c*MO + i]) exp_q.push_back(ev(EV_OBJ, c, i));
        exp_q.push_back(ev(EV_PLAY, 0, 0));
    endtask

    task automatic wait_play(input string tag);
        int n;
        n = 0;
        while (!playing && n < 2000) begin
            tick();
            n++;
        end
        chk(tag, int'(playing), 1);
    endtask

    task automatic wait_obj(input string tag);
        int n;
        n = 0;
        while (!enable_draw_object && n < 200) begin
            tick();
            n++;
        end
        chk(tag, int'(enable_draw_object), 1);
    endtask

    task automatic pulse_go();
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic pulse_frame();
        frame = 1'b1;
        tick();
        frame = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset values
        #3;
        chk("rst_bg_en", int'(enable_draw_background), 0);
        chk("rst_obj_en", int'(enable_draw_object), 0);
        chk("rst_rand", int'(enable_random), 0);
        chk("rst_robj", int'(resetn_objects), 1);
        chk("rst_play", int'(playing), 0);
        chk("rst_cls_idx", int'({obj_class, obj_index}), 0);
        chk("rst_drop", int'(dropped_frames), 0);
        tick();
        resetn = 1'b1;
        tick();

        // Populate with zero-wait draw units
        push_populate();
        go = 1'b1;
        tick();
        go = 1'b0;
        n = 1;
        while (!playing && n < 200) begin
            tick();
            n++;
        end
        chk("populate_latency", n, 28);
        tick();
        chk("populate_drain", exp_q.size(), 0);

        // Redraw with a partial live mask
        obj_alive = 6'b100101;
        push_redraw(6'b100101);
        pulse_frame();
        wait_play("redraw_back_to_play");
        tick();
        chk("redraw_drain", exp_q.size(), 0);
        chk("redraw_drop", int'(dropped_frames), 0);

        // frame and game_end together: end wins, no redraw
        frame = 1'b1;
        game_end = 1'b1;
        tick();
        frame = 1'b0;
        game_end = 1'b0;
        chk("simul_not_playing", int'(playing), 0);
        for (int k = 0; k < 4; k++) tick();
        chk("simul_no_bg", int'(enable_draw_background), 0);
        chk("simul_drain", exp_q.size(), 0);

        // Deferred end with overrun during a stalled redraw
        obj_alive = '1;
        push_populate();
        pulse_go();
        wait_play("defer_populate");
        tick();
        push_redraw('1);
        obj_done = 1'b0;
        pulse_frame();
        wait_obj("defer_obj_start");
        for (int k = 0; k < 20; k++) begin
            frame = (k == 3 || k == 9);
            game_end = (k == 6);
            tick();
        end
        frame = 1'b0;
        game_end = 1'b0;
        obj_done = 1'b1;
        wait_play("defer_reach_play");
        tick();
        chk("defer_play_one_cycle", int'(playing), 0);
        chk("defer_drop", int'(dropped_frames), 2);
        for (int k = 0; k < 3; k++) tick();
        chk("defer_stays_done", int'(enable_draw_background), 0);
        chk("defer_drain", exp_q.size(), 0);

        // Saturation of the overrun counter
        push_populate();
        pulse_go();
        chk("restart_drop_clear", int'(dropped_frames), 0);
        wait_play("sat_populate");
        tick();
        push_redraw('1);
        obj_done = 1'b0;
        pulse_frame();
        wait_obj("sat_obj_start");
        for (int k = 0; k < 300; k++) begin
            pulse_frame();
            tick();
        end
        chk("sat_drop", int'(dropped_frames), 255);
        obj_done = 1'b1;
        wait_play("sat_reach_play");
        game_end = 1'b1;
        tick();
        game_end = 1'b0;
        chk("sat_done", int'(playing), 0);
        push_populate();
        pulse_go();
        chk("sat_go_clear", int'(dropped_frames), 0);
        chk("sat_go_clear_state", int'(resetn_objects), 0);
        wait_play("sat_restart_play");
        tick();
        chk("sat_drain", exp_q.size(), 0);

        // Reset in the middle of an object draw
        exp_q.push_back(ev(EV_BG, 0, 0));
        exp_q.push_back(ev(EV_OBJ, 0, 0));
        obj_done = 1'b0;
        pulse_frame();
        wait_obj("mid_obj_start");
        tick();
        resetn = 1'b0;
        #1;
        chk("mid_obj_en", int'(enable_draw_object), 0);
        chk("mid_bg_en", int'(enable_draw_background), 0);
        chk("mid_rand", int'(enable_random), 0);
        chk("mid_robj", int'(resetn_objects), 1);
        chk("mid_play", int'(playing), 0);
        chk("mid_cls_idx", int'({obj_class, obj_index}), 0);
        go = 1'b1;
        tick();
        tick();
        go = 1'b0;
        tick();
        resetn = 1'b1;
        obj_done = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        chk("mid_idle_robj", int'(resetn_objects), 1);
        chk("mid_idle_bg", int'(enable_draw_background), 0);
        chk("mid_drain", exp_q.size(), 0);
        push_populate();
        pulse_go();
        wait_play("mid_restart_play");
        tick();
        chk("mid_restart_drain", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
